sv39_tlb: RTL
=============

Name: sv39_tlb

Overview:
- Fully-associative Sv39 translation cache that sits directly upstream of the page-table walk unit.
- Translates requester virtual addresses to physical addresses: zero-cycle hit, walker refill on miss.
- The walker returns a leaf PTE normalised to 4 KiB granularity (superpage VPN bits already merged into the PPN field), so every entry maps one 4 KiB page.
- Invalid or non-leaf results are reported as page faults and are never cached.

Parameters:
- ADDR_WIDTH, 64: width of VA, PA, PTE and PPN-base buses.
- ENTRY_NUM, 8: number of entries; power of two, 2..32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  1  translation request; held high with va stable while stall=1.
- va  in  ADDR_WIDTH  virtual address; bits [38:12] form the tag, bits [11:0] the offset.
- satp_ppn  in  ADDR_WIDTH  root page-table PPN, forwarded to the walker.
- flush  in  1  one-cycle pulse; invalidates all entries.
- stall  out  1  requester must hold req/va.
- resp_valid  out  1  pa/page_fault valid this cycle.
- pa  out  ADDR_WIDTH  physical address: {8'b0, ppn[43:0], va[11:0]}.
- page_fault  out  1  translation failed; qualified by resp_valid.
- twu_request  out  1  one-cycle walk start pulse.
- twu_va  out  ADDR_WIDTH  walk VA; stable from twu_request until twu_finish.
- twu_ppn_base  out  ADDR_WIDTH  equals satp_ppn.
- twu_pte  in  ADDR_WIDTH  walker result; valid when twu_finish=1.
- twu_finish  in  1  one-cycle walk-done pulse.

Behaviour:
- Entry contents: valid, tag[26:0] (va[38:12]), ppn[43:0] (pte[53:10]), flags[7:0] (pte[7:0]).
- Reset: all valid bits 0, state IDLE, replacement pointer 0. Outputs are 0: stall, resp_valid, page_fault, twu_request, pa, twu_va.
- States: IDLE, WALK_REQ, WALK_WAIT, REFILL.
- IDLE:
  - hit = req & any(valid & tag==va[38:12]). On hit: resp_valid=1, pa from the hit entry, stall=0, all combinational in the same cycle.
  - req & miss: stall=1; latch va into walk register; next state WALK_REQ.
- WALK_REQ: twu_request=1 for exactly this cycle; stall=1; next state WALK_WAIT.
- WALK_WAIT: stall=1; wait for twu_finish. On twu_finish, latch twu_pte; next state REFILL.
- REFILL:
  - Fault when ~pte.v, or (pte.r|pte.w|pte.x)==0, or (pte.w & ~pte.r).
  - On fault: resp_valid=1, page_fault=1, pa=0, stall=0; no write; next state IDLE.
  - Otherwise: write entry; stall=1; next state IDLE, where the held request hits one cycle later.
- Miss latency: req in cycle 0; twu_request in cycle 1; hit response 2 cycles after twu_finish.
- Victim selection: lowest-index invalid entry if any. Otherwise the round-robin pointer, which increments mod ENTRY_NUM on each replacement.
- twu_va stays constant from the IDLE miss cycle through REFILL.
- flush handling:
  - In IDLE: clears all valid bits at the clock edge; a same-cycle lookup still uses the pre-flush contents.
  - During WALK_REQ/WALK_WAIT: clears valid bits and sets a discard flag. The walk completes normally (the walker cannot be aborted), REFILL writes nothing, and the request re-misses and re-walks.
  - A fault result under a discard flag is still reported.
- twu_finish outside WALK_WAIT is ignored.
- Duplicate tags cannot arise, because only misses trigger fills.
- rst mid-walk returns to IDLE immediately. The walker shares the same system reset, so no stale twu_finish is expected; if one arrives, it is ignored by the rule above.
- twu_request is never reasserted before twu_finish of the current walk.

Test Plan:
- Cold miss then hit: satp_ppn=0x80000, va=0x0000_0000_4000_1234, walker returns pte=0x2000_04CF after 6 cycles. Required: twu_request pulses once in cycle 1, twu_va=0x4000_1234, entry filled; resp_valid with pa=0x8000_1234, page_fault=0, two cycles after finish.
- Repeat hit: same va immediately after. Required: resp_valid=1 and pa=0x8000_1234 in the same cycle, stall=0, no twu_request.
- Fault: va=0x0000_0000_0000_5000, pte=0x0 (v=0). Required: resp_valid=1, page_fault=1 in the REFILL cycle, no fill; a second request to the same va re-walks.
- Replacement: fill 8 distinct pages, then a 9th. Required: entry 0 is evicted; the 1st va misses again and the 2nd va still hits.
- Flush mid-walk: pulse flush during WALK_WAIT. Required: the completed walk is not cached and a second twu_request is issued for the same va; previously cached va's now miss.
- Reset mid-walk: assert rst in WALK_WAIT. Required: stall=0 and all outputs 0 the next cycle; every va misses afterwards.

Source files
------------

// File: rtl/sv39_tlb.sv
// sv39_tlb: fully-associative Sv39 translation cache in front of the walker.
// Hits answer combinationally; misses walk, refill, then replay as a hit.
module sv39_tlb #(
    parameter int ADDR_WIDTH = 64,
    parameter int ENTRY_NUM  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] va,
    input  logic [ADDR_WIDTH-1:0] satp_ppn,
    input  logic                  flush,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [ADDR_WIDTH-1:0] pa,
    output logic                  page_fault,
    output logic                  twu_request,
    output logic [ADDR_WIDTH-1:0] twu_va,
    output logic [ADDR_WIDTH-1:0] twu_ppn_base,
    input  logic [ADDR_WIDTH-1:0] twu_pte,
    input  logic                  twu_finish
);
    localparam int IW = $clog2(ENTRY_NUM);

    typedef enum logic [1:0] {
        IDLE,
        WALK_REQ,
        WALK_WAIT,
        REFILL
    } state_t;

    state_t state, state_nxt;

    logic [ENTRY_NUM-1:0]       valid;
    logic [ENTRY_NUM-1:0][26:0] tag;
    logic [ENTRY_NUM-1:0][43:0] ppn;
    logic [ENTRY_NUM-1:0][7:0]  flags;
    logic [IW-1:0]              rr_ptr;
    logic [ADDR_WIDTH-1:0]      va_q;
    logic [ADDR_WIDTH-1:0]      pte_q;
    logic                       discard;

    logic          hit;
    logic [43:0]   hit_ppn;
    logic          has_free;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] victim;
    logic          pte_fault;
    logic          walking;
    logic          latch_va;
    logic          fill;
    logic          unused_bits;

    // Tags are unique, so OR-ing the matching PPNs selects the single hit.
    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (valid[i] && tag[i] == va[38:12]) begin
                hit     = 1'b1;
                hit_ppn = hit_ppn | ppn[i];
            end
        end
    end

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign victim       = has_free ? free_idx : rr_ptr;
    assign walking      = (state == WALK_REQ) || (state == WALK_WAIT);
    assign twu_ppn_base = satp_ppn;

    assign pte_fault = !pte_q[0]
                     || (pte_q[3:1] == 3'b000)
                     || (pte_q[2] && !pte_q[1]);

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        page_fault  = 1'b0;
        twu_request = 1'b0;
        pa          = '0;
        twu_va      = va_q;
        latch_va    = 1'b0;
        fill        = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && hit) begin
                    resp_valid = 1'b1;
                    pa[55:0]   = {hit_ppn, va[11:0]};
                end else if (req) begin
                    stall     = 1'b1;
                    latch_va  = 1'b1;
                    twu_va    = va;
                    state_nxt = WALK_REQ;
                end
            end
            WALK_REQ: begin
                twu_request = 1'b1;
                stall       = 1'b1;
                state_nxt   = WALK_WAIT;
            end
            WALK_WAIT: begin
                stall = 1'b1;
                if (twu_finish) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                state_nxt = IDLE;
                if (pte_fault) begin
                    resp_valid = 1'b1;
                    page_fault = 1'b1;
                end else begin
                    stall = 1'b1;
                    fill  = !discard;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            stall       = 1'b0;
            resp_valid  = 1'b0;
            page_fault  = 1'b0;
            twu_request = 1'b0;
            pa          = '0;
            twu_va      = '0;
            latch_va    = 1'b0;
            fill        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= '0;
            rr_ptr  <= '0;
            va_q    <= '0;
            pte_q   <= '0;
            discard <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_va) begin
                va_q <= va;
            end
            if (state == WALK_WAIT && twu_finish) begin
                pte_q <= twu_pte;
            end
            if (flush) begin
                valid <= '0;
            end else if (fill) begin
                valid[victim] <= 1'b1;
            end
            if (fill && !flush && !has_free) begin
                rr_ptr <= rr_ptr + IW'(1);
            end
            // A flush mid-walk poisons the in-flight result.
            if (flush && walking) begin
                discard <= 1'b1;
            end else if (state == REFILL) begin
                discard <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !flush) begin
            tag[victim]   <= va_q[38:12];
            ppn[victim]   <= pte_q[53:10];
            flags[victim] <= pte_q[7:0];
        end
    end

    assign unused_bits = ^{va[ADDR_WIDTH-1:39], pte_q[ADDR_WIDTH-1:54],
                           pte_q[9:8], flags};

endmodule
